channel_rx_buffer: RTL and testbench

CHANNEL_RX_BUFFER -- requirements
Module: channel_rx_buffer

---
 rtl/channel_pkg.sv | 39 +++
 rtl/channel_rx_buffer_sat_counter.sv | 22 ++
 rtl/channel_rx_buffer.sv | 187 ++++++++++++++++++
 tb/tb_channel_rx_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared definitions for the channel receive path: link health states,
// per-byte error classification and the link monitor thresholds.
package channel_pkg;

    // Link health as reported to software
    typedef enum logic [1:0] {
        LINK_OK       = 2'b00,
        LINK_DEGRADED = 2'b01,
        LINK_FAILED   = 2'b10
    } link_state_t;

    // Classification of one incoming byte from the error-correcting channel
    typedef enum logic [1:0] {
        BYTE_CLEAN  = 2'b00,
        BYTE_CORR   = 2'b01,
        BYTE_UNCORR = 2'b10
    } byte_class_t;

    // Consecutive uncorrectable bytes that push a degraded link to failed
    localparam int DEGRADE_FAIL_THRESH = 3;

    // Consecutive clean bytes that bring a degraded link back to OK
    localparam int RECOVER_THRESH = 16;

    // A "corrected" flag without a detection is meaningless, so such a byte
    // is treated as clean.
    function automatic byte_class_t classify(input logic det, input logic corr);
        byte_class_t result;
        if (!det) begin
            result = BYTE_CLEAN;
        end else if (corr) begin
            result = BYTE_CORR;
        end else begin
            result = BYTE_UNCORR;
        end
        return result;
    endfunction

endpackage

// File: rtl/channel_rx_buffer_sat_counter.sv
// Saturating statistics counter: holds at all-ones instead of wrapping.
// Clear takes priority over a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at the maximum value, clear on reset or clr
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/channel_rx_buffer.sv
// Receive buffer behind the error-correcting data channel: a show-ahead FIFO
// for usable bytes, saturating error/overflow statistics, and a small link
// health monitor driven by the per-byte error classification.
module channel_rx_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_err_det,
    input  logic                     in_err_corr,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         cnt_corr,
    output logic [CNT_W-1:0]         cnt_uncorr,
    output logic [CNT_W-1:0]         cnt_ovf,
    output logic [1:0]               link_state
);

    import channel_pkg::*;

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int CONSEC_W = $clog2(DEGRADE_FAIL_THRESH + 1);
    localparam int RUN_W    = $clog2(RECOVER_THRESH + 1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;

    byte_class_t in_class;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        storable;
    logic        wr_en;
    logic        ovf_inc;
    logic        corr_inc;
    logic        uncorr_inc;

    link_state_t          state_q;
    link_state_t          state_d;
    logic [CONSEC_W-1:0]  consec_q;
    logic [CONSEC_W-1:0]  consec_d;
    logic [RUN_W-1:0]     run_q;
    logic [RUN_W-1:0]     run_d;

    // Classify the incoming byte and derive the FIFO handshake decisions.
    // Writing into a full FIFO is allowed when the head leaves in the same
    // cycle, since the freed slot is exactly the one being written.
    always_comb begin
        in_class   = classify(in_err_det, in_err_corr);
        fifo_full  = (level_q == LVL_W'(DEPTH));
        fifo_empty = (level_q == '0);
        pop        = !fifo_empty && out_ready;
        storable   = in_valid && (in_class != BYTE_UNCORR);
        wr_en      = storable && (!fifo_full || pop);
        ovf_inc    = storable && fifo_full && !pop;
        corr_inc   = in_valid && (in_class == BYTE_CORR);
        uncorr_inc = in_valid && (in_class == BYTE_UNCORR);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; a byte arriving during reset is discarded
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Show-ahead head of the FIFO, forced to zero while empty so stale
    // storage never leaks to the consumer
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? 8'h00 : mem[rd_ptr];
        level     = level_q;
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_corr (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (corr_inc),
        .count (cnt_corr)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_uncorr (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (uncorr_inc),
        .count (cnt_uncorr)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_ovf (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (ovf_inc),
        .count (cnt_ovf)
    );

    // Link monitor next state. Only valid bytes move the run counters:
    // an uncorrectable byte extends the uncorrectable run and breaks the clean
    // run, a corrected byte breaks both, a clean byte breaks the uncorrectable
    // run and extends the clean run while degraded. FAILED never leaves here.
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        run_d    = run_q;
        if (in_valid) begin
            case (in_class)
                BYTE_UNCORR: begin
                    run_d = '0;
                    if (int'(consec_q) < DEGRADE_FAIL_THRESH) begin
                        consec_d = consec_q + CONSEC_W'(1);
                    end
                    if (state_q == LINK_OK) begin
                        state_d = LINK_DEGRADED;
                    end else if ((state_q == LINK_DEGRADED) &&
                                 (int'(consec_q) + 1 >= DEGRADE_FAIL_THRESH)) begin
                        state_d = LINK_FAILED;
                    end
                end
                BYTE_CORR: begin
                    consec_d = '0;
                    run_d    = '0;
                end
                default: begin
                    consec_d = '0;
                    if (state_q == LINK_DEGRADED) begin
                        if (int'(run_q) + 1 >= RECOVER_THRESH) begin
                            state_d = LINK_OK;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
            endcase
        end
    end

    // Link monitor registers; clearing statistics also restores a healthy link
    always_ff @(posedge clk) begin
        if (!rst || clr_stats) begin
            state_q  <= LINK_OK;
            consec_q <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            run_q    <= run_d;
        end
    end

    assign link_state = state_q;

endmodule

// File: tb/tb_channel_rx_buffer.sv
// Directed, self-checking bench for channel_rx_buffer. A byte queue tracks
// what should come out of the FIFO; a second instance with narrow counters
// exercises counter saturation without millions of cycles.
module tb_channel_rx_buffer;

    import channel_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int SMALL_W = 4;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int SMALL_MAX = (1 << SMALL_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_err_det = 1'b0;
    logic             in_err_corr = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_stats = 1'b0;

    logic             out_valid;
    logic [7:0]       out_data;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_uncorr;
    logic [CNT_W-1:0] cnt_ovf;
    logic [1:0]       link_state;

    logic               s_out_valid;
    logic [7:0]         s_out_data;
    logic [LVL_W-1:0]   s_level;
    logic [SMALL_W-1:0] s_cnt_corr;
    logic [SMALL_W-1:0] s_cnt_uncorr;
    logic [SMALL_W-1:0] s_cnt_ovf;
    logic [1:0]         s_link_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] sb[$];
    int m_corr   = 0;
    int m_uncorr = 0;
    int m_ovf    = 0;

    // Free-running clock
    always #5 clk = ~clk;

    channel_rx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_err_det  (in_err_det),
        .in_err_corr (in_err_corr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .level       (level),
        .clr_stats   (clr_stats),
        .cnt_corr    (cnt_corr),
        .cnt_uncorr  (cnt_uncorr),
        .cnt_ovf     (cnt_ovf),
        .link_state  (link_state)
    );

    channel_rx_buffer #(.DEPTH(DEPTH), .CNT_W(SMALL_W)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_err_det  (in_err_det),
        .in_err_corr (in_err_corr),
        .out_valid   (s_out_valid),
        .out_data    (s_out_data),
        .out_ready   (out_ready),
        .level       (s_level),
        .clr_stats   (clr_stats),
        .cnt_corr    (s_cnt_corr),
        .cnt_uncorr  (s_cnt_uncorr),
        .cnt_ovf     (s_cnt_ovf),
        .link_state  (s_link_state)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // FIFO-facing outputs against the scoreboard queue
    task automatic check_fifo(input string tag);
        check_output({tag, "_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        check_output({tag, "_level"}, 32'(level), 32'(sb.size()));
        check_output({tag, "_data"}, 32'(out_data), (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
    endtask

    task automatic check_stats(input string tag, input logic [1:0] exp_link);
        check_output({tag, "_corr"}, 32'(cnt_corr), 32'(m_corr));
        check_output({tag, "_uncorr"}, 32'(cnt_uncorr), 32'(m_uncorr));
        check_output({tag, "_ovf"}, 32'(cnt_ovf), 32'(m_ovf));
        check_output({tag, "_link"}, 32'(link_state), 32'(exp_link));
    endtask

    // Drive one clock cycle of inputs, update the scoreboard for what the DUT
    // should do at this edge, then check the FIFO outputs just after the edge
    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic det,
                                  input logic corr, input logic rdy, input logic clr);
        logic was_full;
        logic do_pop;
        logic keep;
        in_valid    = v;
        in_data     = d;
        in_err_det  = det;
        in_err_corr = corr;
        out_ready   = rdy;
        clr_stats   = clr;
        was_full = (sb.size() == DEPTH);
        do_pop   = (sb.size() != 0) && rdy;
        keep     = v && !(det && !corr);
        if (do_pop) begin
            check_output("pop_data", 32'(out_data), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (keep && (!was_full || do_pop)) begin
            sb.push_back(d);
        end
        if (clr) begin
            m_corr   = 0;
            m_uncorr = 0;
            m_ovf    = 0;
        end else begin
            if (keep && was_full && !do_pop) m_ovf++;
            if (v && det && corr) m_corr++;
            if (v && det && !corr) m_uncorr++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        check_fifo("cyc");
    endtask

    // Reset with a valid byte and clr_stats asserted, both of which must be ignored
    task automatic do_reset();
        rst         = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'h77;
        in_err_det  = 1'b1;
        in_err_corr = 1'b1;
        clr_stats   = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        m_corr   = 0;
        m_uncorr = 0;
        m_ovf    = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        check_fifo("reset");
        check_stats("reset", LINK_OK);

        // Two clean bytes streamed straight through
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("stream_level", 32'(level), 32'h0);
        check_stats("stream", LINK_OK);

        // Fill past capacity: ninth byte dropped and counted
        for (int i = 0; i < DEPTH + 1; i++) begin
            apply_stimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_output("full_level", 32'(level), 32'(DEPTH));
        check_stats("full", LINK_OK);
        check_output("full_ovf", 32'(cnt_ovf), 32'h1);
        // Push while popping at full is accepted
        apply_stimulus(1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("pushpop_level", 32'(level), 32'(DEPTH));
        check_output("pushpop_ovf", 32'(cnt_ovf), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Corrected byte stored and counted; uncorrectable byte rejected
        apply_stimulus(1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_stats("corr", LINK_OK);
        apply_stimulus(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("uncorr_level", 32'(level), 32'h1);
        check_stats("uncorr", LINK_DEGRADED);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Idle cycle above does not break the run; two more uncorrectable fail the link
        apply_stimulus(1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0);
        check_stats("uncorr2", LINK_DEGRADED);
        apply_stimulus(1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0);
        check_stats("uncorr3", LINK_FAILED);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check_stats("sticky", LINK_FAILED);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("clr_level", 32'(level), 32'h1);
        check_stats("clr", LINK_OK);
        // Clear wins over a same-cycle increment; the byte itself is still stored
        apply_stimulus(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        check_output("clrwin_corr", 32'(cnt_corr), 32'h0);
        check_output("clrwin_level", 32'(level), 32'h2);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Recovery needs sixteen uninterrupted clean bytes
        apply_stimulus(1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 1'b0);
        check_stats("rec_start", LINK_DEGRADED);
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check_stats("rec_15", LINK_DEGRADED);
        apply_stimulus(1'b1, 8'h9F, 1'b1, 1'b1, 1'b1, 1'b0);
        check_stats("rec_corr", LINK_DEGRADED);
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check_stats("rec_15b", LINK_DEGRADED);
        apply_stimulus(1'b1, 8'hBF, 1'b0, 1'b0, 1'b1, 1'b0);
        check_stats("rec_16", LINK_OK);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Saturation on the narrow-counter instance
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SMALL_MAX + 1; i++) begin
            apply_stimulus(1'b1, 8'(8'hE0 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            if (i >= SMALL_MAX - 2) begin
                check_output("sat_small", 32'(s_cnt_uncorr),
                             32'((m_uncorr > SMALL_MAX) ? SMALL_MAX : m_uncorr));
            end
        end
        check_output("sat_wide", 32'(cnt_uncorr), 32'(SMALL_MAX + 1));
        check_output("sat_small_link", 32'(s_link_state), 32'(LINK_FAILED));
        check_output("sat_small_level", 32'(s_level), 32'h0);
        check_output("sat_small_valid", 32'(s_out_valid), 32'h0);
        check_output("sat_small_data", 32'(s_out_data), 32'h0);
        check_output("sat_small_corr", 32'(s_cnt_corr), 32'h0);
        check_output("sat_small_ovf", 32'(s_cnt_ovf), 32'h0);

        // Reset mid-stream discards the FIFO and restores the link
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_output("prerst_level", 32'(level), 32'h5);
        check_stats("prerst", LINK_FAILED);
        do_reset();
        check_fifo("midrst");
        check_stats("midrst", LINK_OK);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
